instr_fetch_responder: RTL and testbench

INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

---
 rtl/instr_fetch_responder.sv | 103 ++++++++++
 tb/tb_instr_fetch_responder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: accepts PC fetch requests, reads a synchronous ROM,
// and returns in-order responses (or address faults) through a small FIFO.
module instr_fetch_responder #(
  parameter int DEPTH  = 2,
  parameter int MEM_AW = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [63:0]       rsp_pc,
  output logic              rsp_fault,
  input  logic              flush,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = DEPTH[CNT_W:0];

  logic [31:0]      fifo_instr [DEPTH];
  logic [63:0]      fifo_pc    [DEPTH];
  logic             fifo_fault [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  // One request in flight while the ROM read completes.
  logic             pend;
  logic [63:0]      pend_pc;
  logic             pend_fault;

  logic             legal;
  logic             accept;
  logic             pop;
  logic             write;
  logic [CNT_W:0]   occupancy;

  assign legal     = (req_addr[1:0] == 2'b00) && (req_addr[63:MEM_AW+2] == '0);
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, pend};
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // A same-cycle pop frees a slot, so rsp_ready feeds req_ready combinationally.
  assign req_ready = reset && !flush && ((occupancy < DEPTH_OCC) || pop);
  assign accept    = req_valid && req_ready;
  assign mem_en    = accept && legal;
  assign mem_addr  = req_addr[MEM_AW+1:2];

  // Flush wins over the pending write, so its ROM data is simply dropped.
  assign write     = pend && !flush;

  assign rsp_instr = rsp_valid ? fifo_instr[head] : '0;
  assign rsp_pc    = rsp_valid ? fifo_pc[head]    : '0;
  assign rsp_fault = rsp_valid ? fifo_fault[head] : 1'b0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend       <= 1'b0;
      pend_pc    <= '0;
      pend_fault <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
    end else if (flush) begin
      pend  <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      pend <= accept;
      if (accept) begin
        pend_pc    <= req_addr;
        pend_fault <= !legal;
      end
      if (write) tail <= tail + 1'b1;
      if (pop)   head <= head + 1'b1;
      unique case ({write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; entries are only observed
  // while count covers them, and the outputs are forced to 0 otherwise.
  always_ff @(posedge clock) begin
    if (write) begin
      fifo_instr[tail] <= pend_fault ? 32'h0 : mem_rdata;
      fifo_pc[tail]    <= pend_pc;
      fifo_fault[tail] <= pend_fault;
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Bench for instr_fetch_responder: ROM model, response scoreboard, vector table,
// and hand-written back-to-back, backpressure, flush and reset sequences.
module tb_instr_fetch_responder;
  localparam int DEPTH  = 2;
  localparam int MEM_AW = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [63:0]       req_addr = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_instr;
  logic [63:0]       rsp_pc;
  logic              rsp_fault;
  logic              flush = 1'b0;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        fault;
  } rsp_t;

  typedef struct {
    logic [63:0] addr;
    logic        fault;
    logic [31:0] instr;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pops   = 0;
  int   n_acc    = 0;
  rsp_t sb[$];
  rsp_t mon_exp;
  rsp_t hold_rsp;
  logic hold = 1'b0;
  logic mon_legal;
  vec_t vecs[8];

  instr_fetch_responder #(.DEPTH(DEPTH), .MEM_AW(MEM_AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_pc    (rsp_pc),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [MEM_AW-1:0] a);
    if (a == 16'd16) return 32'h8B02_0020;
    return {a, ~a} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic is_legal(input logic [63:0] a);
    return (a[1:0] == 2'b00) && (a[63:MEM_AW+2] == '0);
  endfunction

  // Synchronous ROM: data is valid the cycle after mem_en.
  always @(posedge clock) if (mem_en) mem_rdata <= rom_word(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard push on accept, pop/compare on response, idle and hold checks.
  always @(negedge clock) begin
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_instr", 64'(rsp_instr), 64'(hold_rsp.instr));
        check("hold_pc", rsp_pc, hold_rsp.pc);
        check("hold_fault", 64'(rsp_fault), 64'(hold_rsp.fault));
      end
      if (!rsp_valid) begin
        check("idle_instr", 64'(rsp_instr), 64'd0);
        check("idle_pc", rsp_pc, 64'd0);
        check("idle_fault", 64'(rsp_fault), 64'd0);
      end
      if (rsp_valid && rsp_ready) begin
        n_pops++;
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'd1, 64'd0);
        end else begin
          mon_exp = sb.pop_front();
          check("sb_instr", 64'(rsp_instr), 64'(mon_exp.instr));
          check("sb_pc", rsp_pc, mon_exp.pc);
          check("sb_fault", 64'(rsp_fault), 64'(mon_exp.fault));
        end
      end
      if (req_valid && req_ready) begin
        n_acc++;
        mon_legal = is_legal(req_addr);
        check("mem_en", 64'(mem_en), 64'(mon_legal));
        if (mon_legal) check("mem_addr", 64'(mem_addr), 64'(req_addr[MEM_AW+1:2]));
        mon_exp.instr = mon_legal ? rom_word(req_addr[MEM_AW+1:2]) : 32'h0;
        mon_exp.pc    = req_addr;
        mon_exp.fault = !mon_legal;
        sb.push_back(mon_exp);
      end else begin
        check("mem_en_idle", 64'(mem_en), 64'd0);
      end
      if (flush) sb.delete();
      hold = rsp_valid && !rsp_ready && !flush;
      if (hold) begin
        hold_rsp.instr = rsp_instr;
        hold_rsp.pc    = rsp_pc;
        hold_rsp.fault = rsp_fault;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_instr"}, 64'(rsp_instr), 64'd0);
    check({tag, "_rsp_pc"}, rsp_pc, 64'd0);
    check({tag, "_rsp_fault"}, 64'(rsp_fault), 64'd0);
    check({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
  endtask

  initial begin
    int pops0;
    int acc0;
    int k;

    vecs[0] = '{64'h40,                  1'b0, 32'h8B02_0020};
    vecs[1] = '{64'h42,                  1'b1, 32'h0};
    vecs[2] = '{64'h0004_0000,           1'b1, 32'h0};
    vecs[3] = '{64'h0003_FFFC,           1'b0, rom_word(16'hFFFF)};
    vecs[4] = '{64'h0,                   1'b0, rom_word(16'h0000)};
    vecs[5] = '{64'h8000_0000_0000_0000, 1'b1, 32'h0};
    vecs[6] = '{64'h0001_0001,           1'b1, 32'h0};
    vecs[7] = '{64'h0001_0000,           1'b0, rom_word(16'h4000)};

    // Outputs while held in reset, with a request presented.
    req_valid = 1'b1;
    req_addr  = 64'h40;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    req_valid = 1'b0;

    // Release reset; vector 0 is presented in the first cycle after release.
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) cyc();
      req_valid = 1'b1;
      req_addr  = vecs[i].addr;
      rsp_ready = 1'b0;
      @(negedge clock);
      check("vec_req_ready", 64'(req_ready), 64'd1);
      check("vec_mem_en", 64'(mem_en), 64'(!vecs[i].fault));
      cyc();
      req_valid = 1'b0;
      @(negedge clock);
      check("vec_pending_valid", 64'(rsp_valid), 64'd0);
      cyc();
      @(negedge clock);
      check("vec_rsp_valid", 64'(rsp_valid), 64'd1);
      check("vec_rsp_instr", 64'(rsp_instr), 64'(vecs[i].instr));
      check("vec_rsp_pc", rsp_pc, vecs[i].addr);
      check("vec_rsp_fault", 64'(rsp_fault), 64'(vecs[i].fault));
      cyc();
      rsp_ready = 1'b1;
      @(negedge clock);
      cyc();
      rsp_ready = 1'b0;
      @(negedge clock);
      check("vec_drained", 64'(rsp_valid), 64'd0);
    end

    // Back-to-back requests with the consumer always ready.
    cyc();
    rsp_ready = 1'b1;
    pops0     = n_pops;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) cyc();
      req_valid = 1'b1;
      req_addr  = 64'(i * 4);
      @(negedge clock);
      check("b2b_req_ready", 64'(req_ready), 64'd1);
      if (i >= 2) check("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
    end
    cyc();
    req_valid = 1'b0;
    @(negedge clock);
    check("b2b_tail_valid0", 64'(rsp_valid), 64'd1);
    cyc();
    @(negedge clock);
    check("b2b_tail_valid1", 64'(rsp_valid), 64'd1);
    cyc();
    @(negedge clock);
    check("b2b_done_valid", 64'(rsp_valid), 64'd0);
    check("b2b_pop_count", 64'(n_pops - pops0), 64'd4);
    check("b2b_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: continuous requests, consumer stalled.
    cyc();
    rsp_ready = 1'b0;
    acc0      = n_acc;
    pops0     = n_pops;
    k         = 0;
    req_valid = 1'b1;
    req_addr  = 64'h100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (req_ready) k++;
      cyc();
      req_addr = 64'h100 + 64'(k * 4);
    end
    @(negedge clock);
    check("bp_req_ready_low", 64'(req_ready), 64'd0);
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    check("bp_accepted", 64'(n_acc - acc0), 64'(DEPTH));
    cyc();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (DEPTH + 2) @(negedge clock);
    check("bp_drain_pops", 64'(n_pops - pops0), 64'(DEPTH));
    check("bp_sb_empty", 64'(sb.size()), 64'd0);
    check("bp_drained", 64'(rsp_valid), 64'd0);

    // Flush with the FIFO holding one entry and one request pending.
    cyc();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 64'h200;
    @(negedge clock);
    cyc();
    req_addr = 64'h204;
    @(negedge clock);
    cyc();
    req_addr = 64'h208;
    flush    = 1'b1;
    @(negedge clock);
    check("flush_req_ready", 64'(req_ready), 64'd0);
    cyc();
    flush     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    check("flush_req_ready_after", 64'(req_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      cyc();
      @(negedge clock);
      check("flush_no_stale", 64'(rsp_valid), 64'd0);
    end
    cyc();
    req_valid = 1'b1;
    req_addr  = 64'h40;
    @(negedge clock);
    cyc();
    req_valid = 1'b0;
    @(negedge clock);
    cyc();
    @(negedge clock);
    check("post_flush_valid", 64'(rsp_valid), 64'd1);
    check("post_flush_instr", 64'(rsp_instr), 64'h8B02_0020);
    cyc();
    @(negedge clock);
    check("post_flush_sb_empty", 64'(sb.size()), 64'd0);

    // Asynchronous reset mid-stream, asserted between clock edges.
    cyc();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 64'h300;
    @(negedge clock);
    cyc();
    req_addr = 64'h304;
    @(negedge clock);
    cyc();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("rst_release_ready", 64'(req_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      @(negedge clock);
      check("rst_no_stale", 64'(rsp_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
